// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    // Sequencing states of the hazard controller
    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LD_STALL = 2'b01,
        MD_BUSY  = 2'b10
    } hazState_t;

    // Execute-stage operand source selects
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Default number of cycles a mul/div op occupies execute
    localparam int MD_LATENCY_DEF = 4;

    // A load in execute whose destination is read by the instruction in decode
    function automatic logic isLoadUse(
        input logic       memtoRegE,
        input logic       regWriteE,
        input logic [4:0] rdE,
        input logic [4:0] rs1D,
        input logic [4:0] rs2D
    );
        return memtoRegE && regWriteE && (rdE != 5'd0) &&
               ((rdE == rs1D) || (rdE == rs2D));
    endfunction

endpackage

// File: rtl/hazard_controller_forward_unit.sv
// Per-operand forwarding select: memory stage wins over writeback,
// and register x0 is never forwarded.
import hazard_pkg::*;

module forward_unit (
    input  logic [4:0] rsE,
    input  logic [4:0] writeRegM,
    input  logic       regWriteM,
    input  logic [4:0] writeRegW,
    input  logic       regWriteW,
    output logic [1:0] forward
);

    // Pick the youngest in-flight producer of rsE
    always_comb begin
        forward = FWD_RF;
        if (regWriteM && (writeRegM != 5'd0) && (writeRegM == rsE)) begin
            forward = FWD_MEM;
        end else if (regWriteW && (writeRegW != 5'd0) && (writeRegW == rsE)) begin
            forward = FWD_WB;
        end else begin
            forward = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Hazard, forwarding and mul/div sequencing controller for the 5-stage pipeline.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined;
// otherwise stall_count/flush_count are tied to zero.
import hazard_pkg::*;

module hazard_controller #(
    parameter int MD_LATENCY = MD_LATENCY_DEF,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic             RegWriteE,
    input  logic             MemtoRegE,
    input  logic             MdOpE,
    input  logic [4:0]       WriteRegM,
    input  logic             RegWriteM,
    input  logic [4:0]       WriteRegW,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             BubbleM,
    output logic             md_start,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY - 1);

    hazState_t  state_r;
    hazState_t  stateNext_s;
    logic [3:0] mdCnt_r;
    logic [3:0] mdCntNext_s;
    logic       loadUse_s;

    forward_unit u_fwdA (
        .rsE       (Rs1E),
        .writeRegM (WriteRegM),
        .regWriteM (RegWriteM),
        .writeRegW (WriteRegW),
        .regWriteW (RegWriteW),
        .forward   (ForwardAE)
    );

    forward_unit u_fwdB (
        .rsE       (Rs2E),
        .writeRegM (WriteRegM),
        .regWriteM (RegWriteM),
        .writeRegW (WriteRegW),
        .regWriteW (RegWriteW),
        .forward   (ForwardBE)
    );

    assign loadUse_s = isLoadUse(MemtoRegE, RegWriteE, RdE, Rs1D, Rs2D);

    // State and mul/div occupancy counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RUN;
            mdCnt_r <= 4'd0;
        end else begin
            state_r <= stateNext_s;
            mdCnt_r <= mdCntNext_s;
        end
    end

    // Next state and pipeline control. The detection cycle of a hazard drives
    // the controls directly; LD_STALL only masks re-detection of the same load.
    always_comb begin
        stateNext_s = state_r;
        mdCntNext_s = mdCnt_r;
        StallF      = 1'b0;
        StallD      = 1'b0;
        StallE      = 1'b0;
        FlushD      = 1'b0;
        FlushE      = 1'b0;
        BubbleM     = 1'b0;
        md_start    = 1'b0;
        md_busy     = 1'b0;
        if (rst) begin
            stateNext_s = RUN;
            mdCntNext_s = 4'd0;
        end else begin
            case (state_r)
                RUN: begin
                    if (MdOpE) begin
                        stateNext_s = MD_BUSY;
                        mdCntNext_s = MD_LOAD;
                        md_start    = 1'b1;
                        md_busy     = 1'b1;
                        StallF      = 1'b1;
                        StallD      = 1'b1;
                        StallE      = 1'b1;
                        BubbleM     = 1'b1;
                    end else if (PCSrcE) begin
                        // A taken branch squashes the dependent instruction,
                        // so no load-use stall is needed.
                        FlushD = 1'b1;
                        FlushE = 1'b1;
                    end else if (loadUse_s) begin
                        stateNext_s = LD_STALL;
                        StallF      = 1'b1;
                        StallD      = 1'b1;
                        FlushE      = 1'b1;
                    end else begin
                        stateNext_s = RUN;
                    end
                end
                LD_STALL: begin
                    stateNext_s = RUN;
                    if (PCSrcE) begin
                        FlushD = 1'b1;
                        FlushE = 1'b1;
                    end else begin
                        FlushD = 1'b0;
                    end
                end
                MD_BUSY: begin
                    // Branches are ignored while the unit holds execute
                    StallF  = 1'b1;
                    StallD  = 1'b1;
                    StallE  = 1'b1;
                    BubbleM = 1'b1;
                    md_busy = 1'b1;
                    if (mdCnt_r <= 4'd1) begin
                        stateNext_s = RUN;
                        mdCntNext_s = 4'd0;
                    end else begin
                        mdCntNext_s = mdCnt_r - 4'd1;
                    end
                end
                default: begin
                    stateNext_s = RUN;
                    mdCntNext_s = 4'd0;
                end
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stallCnt_r;
    logic [CNT_W-1:0] flushCnt_r;

    // Saturating counts of fetch-stall and execute-flush cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            stallCnt_r <= {CNT_W{1'b0}};
            flushCnt_r <= {CNT_W{1'b0}};
        end else begin
            if (StallF && (stallCnt_r != {CNT_W{1'b1}})) begin
                stallCnt_r <= stallCnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stallCnt_r <= stallCnt_r;
            end
            if (FlushE && (flushCnt_r != {CNT_W{1'b1}})) begin
                flushCnt_r <= flushCnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                flushCnt_r <= flushCnt_r;
            end
        end
    end

    assign stall_count = stallCnt_r;
    assign flush_count = flushCnt_r;
`else
    assign stall_count = {CNT_W{1'b0}};
    assign flush_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller (MD_LATENCY=4, CNT_W=4).
module tb_hazard_controller;

`ifdef HAZ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, WriteRegM, WriteRegW;
    logic       RegWriteE, MemtoRegE, MdOpE, RegWriteM, RegWriteW, PCSrcE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, FlushD, FlushE, BubbleM, md_start, md_busy;
    logic [3:0] stall_count, flush_count;

    int checks = 0;
    int errors = 0;

    hazard_controller #(.MD_LATENCY(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MdOpE(MdOpE),
        .WriteRegM(WriteRegM), .RegWriteM(RegWriteM),
        .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
        .PCSrcE(PCSrcE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .BubbleM(BubbleM),
        .md_start(md_start), .md_busy(md_busy),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0; RdE = 5'd0;
        WriteRegM = 5'd0; WriteRegW = 5'd0;
        RegWriteE = 1'b0; MemtoRegE = 1'b0; MdOpE = 1'b0;
        RegWriteM = 1'b0; RegWriteW = 1'b0; PCSrcE = 1'b0;
    endtask

    task automatic setLoadUse();
        MemtoRegE = 1'b1; RegWriteE = 1'b1; RdE = 5'd3; Rs2D = 5'd3;
    endtask

    // Stall/flush/bubble/busy group compared as one packed value {F,D,E,FD,FE,BM,start,busy}
    function automatic int ctl();
        return int'({StallF, StallD, StallE, FlushD, FlushE, BubbleM, md_start, md_busy});
    endfunction

    initial begin
        clearInputs();
        rst = 1'b1;
        nextCycle();
        nextCycle();
        @(negedge clk);
        checkVal("rst_fwdA", ForwardAE, 0);
        checkVal("rst_fwdB", ForwardBE, 0);
        checkVal("rst_ctl", ctl(), 0);
        checkVal("rst_stallcnt", stall_count, 0);
        checkVal("rst_flushcnt", flush_count, 0);
        nextCycle();
        rst = 1'b0;

        // Forwarding
        RegWriteM = 1'b1; WriteRegM = 5'd5; RegWriteW = 1'b1; WriteRegW = 5'd5; Rs1E = 5'd5;
        @(negedge clk);
        checkVal("fwdA_mem_prio", ForwardAE, 2);
        checkVal("fwdB_x0", ForwardBE, 0);
        WriteRegM = 5'd6;
        @(negedge clk);
        checkVal("fwdA_wb", ForwardAE, 1);
        Rs2E = 5'd6;
        @(negedge clk);
        checkVal("fwdB_mem", ForwardBE, 2);
        WriteRegM = 5'd0; WriteRegW = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        @(negedge clk);
        checkVal("fwdA_no_x0", ForwardAE, 0);
        checkVal("fwdB_no_x0", ForwardBE, 0);
        RegWriteM = 1'b0; WriteRegW = 5'd5; Rs1E = 5'd5;
        @(negedge clk);
        checkVal("fwdA_wb_only", ForwardAE, 1);
        RegWriteW = 1'b0;
        @(negedge clk);
        checkVal("fwdA_no_we", ForwardAE, 0);
        clearInputs();
        nextCycle();

        // Load-use: one stall cycle, then masked even with inputs held
        setLoadUse();
        @(negedge clk);
        checkVal("lu_ctl", ctl(), 8'b1100_1000);
        nextCycle();
        @(negedge clk);
        checkVal("lu_release", ctl(), 0);
        clearInputs();
        nextCycle();
        @(negedge clk);
        checkVal("lu_stallcnt", stall_count, PERF ? 1 : 0);
        checkVal("lu_flushcnt", flush_count, PERF ? 1 : 0);
        MemtoRegE = 1'b1; RegWriteE = 1'b1; RdE = 5'd0;
        @(negedge clk);
        checkVal("lu_rd0", ctl(), 0);
        clearInputs();
        nextCycle();

        // Branch overrides load-use
        setLoadUse();
        PCSrcE = 1'b1;
        @(negedge clk);
        checkVal("br_over_lu", ctl(), 8'b0001_1000);
        nextCycle();
        clearInputs();
        @(negedge clk);
        checkVal("br_after", ctl(), 0);
        checkVal("br_flushcnt", flush_count, PERF ? 2 : 0);
        nextCycle();

        // Mul/div occupancy of four cycles
        MdOpE = 1'b1;
        @(negedge clk);
        checkVal("md_c0", ctl(), 8'b1110_0111);
        nextCycle();
        PCSrcE = 1'b1;
        @(negedge clk);
        checkVal("md_c1_br_ignored", ctl(), 8'b1110_0101);
        nextCycle();
        PCSrcE = 1'b0;
        @(negedge clk);
        checkVal("md_c2", ctl(), 8'b1110_0101);
        nextCycle();
        @(negedge clk);
        checkVal("md_c3", ctl(), 8'b1110_0101);
        nextCycle();
        MdOpE = 1'b0;
        @(negedge clk);
        checkVal("md_done", ctl(), 0);
        checkVal("md_stallcnt", stall_count, PERF ? 5 : 0);
        nextCycle();

        // Reset during the second MD_BUSY cycle
        MdOpE = 1'b1;
        nextCycle();
        nextCycle();
        rst = 1'b1;
        MdOpE = 1'b0;
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkVal("rstmid_ctl", ctl(), 0);
        checkVal("rstmid_stallcnt", stall_count, 0);
        checkVal("rstmid_flushcnt", flush_count, 0);
        nextCycle();
        @(negedge clk);
        checkVal("rstmid_idle", ctl(), 0);
        nextCycle();

        // Twenty consecutive stall cycles saturate the 4-bit counter
        MdOpE = 1'b1;
        for (int i = 0; i < 20; i++) begin
            nextCycle();
        end
        MdOpE = 1'b0;
        @(negedge clk);
        checkVal("sat_stallcnt", stall_count, PERF ? 15 : 0);
        checkVal("sat_flushcnt", flush_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
